// File: rtl/seg7_pkg.sv
// Shared constants for the two-digit multiplexed 7-segment scanner:
// active-high segment patterns {g,f,e,d,c,b,a} and the scan state encoding.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_MINUS = 7'h40;
   localparam logic [6:0] SEG_OFF   = 7'h00;

   // Scan order: units lit, gap, tens lit, gap, back to units.
   typedef enum logic [1:0] {
      S_UNITS = 2'd0,
      S_GAP0  = 2'd1,
      S_TENS  = 2'd2,
      S_GAP1  = 2'd3
   } state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-high 7-segment pattern.
// Non-BCD codes (A-F) display a minus sign so bad upstream data is visible.
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] pattern
);

   // Lookup of the digit glyph.
   always_comb begin
      // NOTE: the default arm assigns every code, so no latch can be inferred.
      case (digit)
         4'd0:    pattern = SEG_0;
         4'd1:    pattern = SEG_1;
         4'd2:    pattern = SEG_2;
         4'd3:    pattern = SEG_3;
         4'd4:    pattern = SEG_4;
         4'd5:    pattern = SEG_5;
         4'd6:    pattern = SEG_6;
         4'd7:    pattern = SEG_7;
         4'd8:    pattern = SEG_8;
         4'd9:    pattern = SEG_9;
         default: pattern = SEG_MINUS;
      endcase
   end

endmodule

// File: rtl/bcd_seg7_scan.sv
// Two-digit time-multiplexed 7-segment driver with blanking gaps between
// digits. New BCD values are shadowed on in_valid and committed to the
// display only at the frame boundary so both digits change together.
// Optional feature macro: BCD_SEG7_LZ_BLANK_EN (leading-zero blanking of tens).
module bcd_seg7_scan
   import seg7_pkg::*;
#(
   parameter int unsigned REFRESH_DIV    = 50000,
   parameter int unsigned BLANK_CYCLES   = 16,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [3:0] bcd_tens,
   input  logic [3:0] bcd_units,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       frame_sync
);

   localparam int unsigned MAX_DUR  = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int unsigned CW       = $clog2(MAX_DUR + 1);
   localparam logic [CW-1:0] LIT_LAST   = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [6:0] SEG_XOR = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [1:0] AN_XOR  = AN_ACTIVE_LOW  ? 2'b11 : 2'b00;

   state_t        state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic [7:0]    shadow;
   logic [7:0]    display, display_next;
   logic          pending, pending_next;
   logic          done;
   logic [3:0]    digit;
   logic [6:0]    pattern;
   logic [6:0]    seg_hi;
   logic [1:0]    an_hi;
   logic          frame_sync_next;

   // Sequencing: count cycles in the current state, advance and reload at the end.
   always_comb begin
      state_next   = state;
      cnt_next     = cnt + CW'(1);
      display_next = display;
      pending_next = pending;
      done         = 1'b0;
      unique case (state)
         S_UNITS: if (cnt == LIT_LAST)   begin done = 1'b1; state_next = S_GAP0;  end
         S_GAP0:  if (cnt == BLANK_LAST) begin done = 1'b1; state_next = S_TENS;  end
         S_TENS:  if (cnt == LIT_LAST)   begin done = 1'b1; state_next = S_GAP1;  end
         S_GAP1:  if (cnt == BLANK_LAST) begin done = 1'b1; state_next = S_UNITS; end
         default: begin done = 1'b1; state_next = S_GAP1; end
      endcase
      if (done)
         cnt_next = '0;
      // Frame boundary: a strobe on this very edge beats the older shadow copy.
      if (done && state == S_GAP1) begin
         pending_next = 1'b0;
         if (in_valid)
            display_next = {bcd_tens, bcd_units};
         else if (pending)
            display_next = shadow;
      end else if (in_valid) begin
         pending_next = 1'b1;
      end
   end

   // One shared decoder on whichever digit will be lit after this edge.
   assign digit = (state_next == S_TENS) ? display_next[7:4] : display_next[3:0];

   bcd_to_seg7 u_dec (
      .digit   (digit),
      .pattern (pattern)
   );

   // Output pre-decode from the next state so pins move on the same edge as the state.
   always_comb begin
      an_hi  = 2'b00;
      seg_hi = SEG_OFF;
      unique case (state_next)
         S_UNITS: begin an_hi = 2'b01; seg_hi = pattern; end
         S_TENS: begin
`ifdef BCD_SEG7_LZ_BLANK_EN
            if (display_next[7:4] != 4'd0) begin
               an_hi  = 2'b10;
               seg_hi = pattern;
            end
`else
            an_hi  = 2'b10;
            seg_hi = pattern;
`endif
         end
         default: begin an_hi = 2'b00; seg_hi = SEG_OFF; end
      endcase
      frame_sync_next = (state == S_GAP1) && (state_next == S_UNITS);
   end

   // State, data and registered output pins; reset blanks the display at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_GAP1;
         cnt        <= '0;
         shadow     <= '0;
         display    <= '0;
         pending    <= 1'b0;
         seg        <= SEG_OFF ^ SEG_XOR;
         an         <= AN_XOR;
         frame_sync <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state      <= state_next;
         cnt        <= cnt_next;
         display    <= display_next;
         pending    <= pending_next;
         if (in_valid)
            shadow <= {bcd_tens, bcd_units};
         seg        <= seg_hi ^ SEG_XOR;
         an         <= an_hi ^ AN_XOR;
         frame_sync <= frame_sync_next;
      end
   end

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Self-checking bench for bcd_seg7_scan with REFRESH_DIV=4, BLANK_CYCLES=2,
// active-low pins: 12-cycle frames checked cycle by cycle.
module tb_bcd_seg7_scan;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] bcd_tens;
   logic [3:0] bcd_units;
   logic [6:0] seg;
   logic [1:0] an;
   logic       frame_sync;

   int checks = 0;
   int errors = 0;

   bcd_seg7_scan #(
      .REFRESH_DIV    (4),
      .BLANK_CYCLES   (2),
      .SEG_ACTIVE_LOW (1'b1),
      .AN_ACTIVE_LOW  (1'b1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .bcd_tens   (bcd_tens),
      .bcd_units  (bcd_units),
      .seg        (seg),
      .an         (an),
      .frame_sync (frame_sync)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] tens;
      logic [3:0] units;
      logic [6:0] u_pat;
      logic [6:0] t_pat;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic lz(input logic [3:0] t);
`ifdef BCD_SEG7_LZ_BLANK_EN
      return t == 4'd0;
`else
      return 1'b0;
`endif
   endfunction

   task automatic check_off(input string name);
      check({name, " an"}, {6'd0, an}, 8'h03);
      check({name, " seg"}, {1'b0, seg}, 8'h7F);
      check({name, " fs"}, {7'd0, frame_sync}, 8'h00);
   endtask

   // Checks one frame starting at its first units cycle; optional strobes at cycle sa/sb.
   task automatic check_frame(input string tag, input logic [6:0] u_pat, input logic [6:0] t_pat,
                              input logic t_blank,
                              input int sa, input logic [3:0] sa_t, input logic [3:0] sa_u,
                              input int sb, input logic [3:0] sb_t, input logic [3:0] sb_u);
      logic [1:0] e_an;
      logic [6:0] e_seg;
      for (int i = 0; i < 12; i++) begin
         if (i < 4) begin
            e_an = 2'b10; e_seg = ~u_pat;
         end else if (i >= 6 && i < 10 && !t_blank) begin
            e_an = 2'b01; e_seg = ~t_pat;
         end else begin
            e_an = 2'b11; e_seg = 7'h7F;
         end
         check($sformatf("%s c%0d an", tag, i), {6'd0, an}, {6'd0, e_an});
         check($sformatf("%s c%0d seg", tag, i), {1'b0, seg}, {1'b0, e_seg});
         check($sformatf("%s c%0d fs", tag, i), {7'd0, frame_sync}, {7'd0, (i == 0)});
         if (i == sa) begin
            in_valid = 1'b1; bcd_tens = sa_t; bcd_units = sa_u;
         end else if (i == sb) begin
            in_valid = 1'b1; bcd_tens = sb_t; bcd_units = sb_u;
         end else begin
            in_valid = 1'b0; bcd_tens = 4'hE; bcd_units = 4'hE;
         end
         step();
      end
      in_valid = 1'b0;
   endtask

   initial begin
      vecs[0] = '{4'd0, 4'd5, 7'h6D, 7'h3F};
      vecs[1] = '{4'd1, 4'd2, 7'h5B, 7'h06};
      vecs[2] = '{4'd3, 4'd4, 7'h66, 7'h4F};
      vecs[3] = '{4'd6, 4'd9, 7'h6F, 7'h7D};
      vecs[4] = '{4'd7, 4'd0, 7'h3F, 7'h07};
      vecs[5] = '{4'd8, 4'hC, 7'h40, 7'h7F};
      vecs[6] = '{4'hF, 4'd8, 7'h7F, 7'h40};
      vecs[7] = '{4'd5, 4'hA, 7'h40, 7'h6D};
      vecs[8] = '{4'd2, 4'd3, 7'h4F, 7'h5B};

      rst_n = 1'b1; in_valid = 1'b0; bcd_tens = 4'd0; bcd_units = 4'd0;
      #2 rst_n = 1'b0;
      #1 check_off("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check_off("post-rst 0");
      step();
      check_off("post-rst 1");
      step();

      // Reset value 0,0; strobe 2,7 early in the frame must wait for the next frame.
      check_frame("f0", 7'h3F, 7'h3F, lz(4'd0), 0, 4'd2, 4'd7, -1, 4'd0, 4'd0);
      // Shows 2,7; two strobes, last wins.
      check_frame("f1", 7'h07, 7'h5B, 1'b0, 1, 4'd3, 4'd1, 7, 4'd9, 4'd8);
      // Shows 9,8; pending 3,3 then a strobe on the boundary edge (4,5) wins.
      check_frame("f2", 7'h7F, 7'h6F, 1'b0, 2, 4'd3, 4'd3, 11, 4'd4, 4'd5);
      // Shows 4,5 already; queue the first table vector.
      check_frame("f3", 7'h6D, 7'h66, 1'b0, 3, vecs[0].tens, vecs[0].units, -1, 4'd0, 4'd0);

      for (int k = 0; k < 9; k++) begin
         if (k < 8)
            check_frame($sformatf("v%0d", k), vecs[k].u_pat, vecs[k].t_pat, lz(vecs[k].tens),
                        3, vecs[k+1].tens, vecs[k+1].units, -1, 4'd0, 4'd0);
         else
            check_frame($sformatf("v%0d", k), vecs[k].u_pat, vecs[k].t_pat, lz(vecs[k].tens),
                        -1, 4'd0, 4'd0, -1, 4'd0, 4'd0);
      end
      // No strobe: value held.
      check_frame("hold", 7'h4F, 7'h5B, 1'b0, -1, 4'd0, 4'd0, -1, 4'd0, 4'd0);

      // Reset in the middle of the tens digit.
      repeat (7) step();
      check("mid-tens an", {6'd0, an}, 8'h01);
      #2 rst_n = 1'b0;
      #1 check_off("mid rst");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check_off("re-rst 0");
      step();
      check_off("re-rst 1");
      step();
      check_frame("after-rst", 7'h3F, 7'h3F, lz(4'd0), -1, 4'd0, 4'd0, -1, 4'd0, 4'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
